// File: rtl/cpu_program_loader.sv
// cpu_program_loader
// Turns a host byte stream (16-bit little-endian word count, then
// little-endian instruction words) into single-cycle instruction memory
// writes at consecutive addresses from 0. The CPU is held halted for the
// whole upload, and also after an aborted (oversized) upload, because the
// memory contents are not valid then.

module cpu_program_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 1024,
    parameter int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_halt,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    // The header is 16 bits; comparing at 17 bits keeps SIZE=65536 legal.
    localparam logic [16:0]       SIZE_EXT  = 17'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    done_q, done_d;

    logic                    xfer;
    logic [15:0]             hdr_len;

    // A byte moves only when this block is ready and the host offers one.
    assign xfer    = in_valid && in_ready;
    // Full word count once the high header byte is on the bus.
    assign hdr_len = {in_data, len_lo_q};

    // Output decode: everything except done is a pure function of state.
    always_comb begin
        in_ready     = 1'b0;
        busy         = 1'b0;
        error        = 1'b0;
        cpu_halt     = 1'b0;
        write_enable = 1'b0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                cpu_halt = 1'b1;
            end
            S_WRITE: begin
                busy         = 1'b1;
                cpu_halt     = 1'b1;
                write_enable = 1'b1;
            end
            S_ERROR: begin
                error    = 1'b1;
                cpu_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign done       = done_q;
    assign write_addr = addr_q;
    assign write_data = word_q;

    // Next-state logic for the sequencer and its counters.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                if (xfer) begin
                    if (hdr_len == 16'd0) begin
                        // Empty program: finish at once, nothing written.
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if ({1'b0, hdr_len} > SIZE_EXT) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d     = S_DATA;
                        addr_d      = '0;
                        byte_idx_d  = '0;
                        remaining_d = hdr_len;
                    end
                end
            end

            S_DATA: begin
                if (xfer) begin
                    // First byte of a word lands in the least significant lane.
                    for (int b = 0; b < BYTES; b++) begin
                        if (byte_idx_q == BIDX_W'(b)) begin
                            word_d[8*b +: 8] = in_data;
                        end
                    end
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = S_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                    end
                end
            end

            S_WRITE: begin
                // The write happens this cycle; advance for the next word.
                addr_d      = addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - 16'd1;
                byte_idx_d  = '0;
                if (remaining_q == 16'd1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end

            S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any upload in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_lo_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Testbench for cpu_program_loader: byte uploads with optional random
// valid gaps and stray start pulses, compared against a reference model
// that decodes the byte list directly into the expected memory writes.

module tb_cpu_program_loader;

    localparam int DW = 16;
    localparam int SZ = 1024;
    localparam int AW = $clog2(SZ);
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_halt;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int viol = 0;
    int halt_tot = 0;
    bit prev_we = 1'b0;

    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    int            dq_cyc[$];
    logic [3:0]    dq_flags[$];
    logic [7:0]    txq[$];

    cpu_program_loader #(
        .DATA_WIDTH(DW),
        .SIZE      (SZ),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_halt    (cpu_halt),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .write_data  (write_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record writes, done pulses and halt cycles; flag protocol violations.
    always @(negedge clk) begin
        if (write_enable) begin
            wq_addr.push_back(write_addr);
            wq_data.push_back(write_data);
        end
        if (cpu_halt) halt_tot++;
        if (done) begin
            dq_cyc.push_back(cyc);
            dq_flags.push_back({cpu_halt, busy, write_enable, error});
        end
        if (write_enable && prev_we) viol++;
        if (done && (write_enable || error)) viol++;
        prev_we = write_enable;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int sc);
        start = 1'b1;
        sc    = cyc;
        tick();
        start = 1'b0;
    endtask

    // Offer txq bytes in order; a byte only advances once it was accepted.
    task automatic send_bytes(input bit gaps, input bit mid_start, input int abort_after);
        int idx   = 0;
        int guard = 0;
        int bw    = wq_addr.size();
        bit take;
        while (idx < txq.size() && guard < 20000) begin
            if (abort_after > 0 && (wq_addr.size() - bw) >= abort_after) break;
            in_data  = txq[idx];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = mid_start && ($urandom_range(0, 63) == 0);
            @(negedge clk);
            take = in_valid && in_ready;
            tick();
            if (take) idx++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (guard >= 20000) chk("send_timeout", 32'(idx), 32'(txq.size()));
    endtask

    // Run one upload of txq and compare with the decoded expectation.
    task automatic run_load(input string name, input bit gaps, input bit mid_start, input bit timed);
        int bw, bd, bh, sc, n;
        logic [DW-1:0] w;
        bw = wq_addr.size();
        bd = dq_cyc.size();
        bh = halt_tot;
        do_start(sc);
        send_bytes(gaps, mid_start, 0);
        repeat (4) tick();
        n = int'({txq[1], txq[0]});
        if (n > SZ) begin
            chk({name, " error"},    32'(error), 32'd1);
            chk({name, " in_ready"}, 32'(in_ready), 32'd0);
            chk({name, " cpu_halt"}, 32'(cpu_halt), 32'd1);
            chk({name, " busy"},     32'(busy), 32'd0);
            chk({name, " writes"},   32'(wq_addr.size() - bw), 32'd0);
            chk({name, " dones"},    32'(dq_cyc.size() - bd), 32'd0);
        end else begin
            chk({name, " writes"}, 32'(wq_addr.size() - bw), 32'(n));
            for (int i = 0; i < n && (bw + i) < wq_addr.size(); i++) begin
                w = '0;
                for (int b = 0; b < NB; b++) w[8*b +: 8] = txq[2 + i*NB + b];
                chk($sformatf("%s w%0d addr", name, i), 32'(wq_addr[bw + i]), 32'(i));
                chk($sformatf("%s w%0d data", name, i), 32'(wq_data[bw + i]), 32'(w));
            end
            chk({name, " dones"}, 32'(dq_cyc.size() - bd), 32'd1);
            if (dq_cyc.size() > bd) begin
                chk({name, " done_flags"}, 32'(dq_flags[bd]), 32'd0);
                if (timed) chk({name, " done_cycle"}, 32'(dq_cyc[bd]), 32'(sc + 3 + n*(NB + 1)));
            end
            if (timed) chk({name, " halt_cycles"}, 32'(halt_tot - bh), 32'(2 + n*(NB + 1)));
            chk({name, " error_after"}, 32'(error), 32'd0);
            chk({name, " busy_after"},  32'(busy), 32'd0);
        end
    endtask

    initial begin
        int sc, bw, n;
        bit g;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst busy",     32'(busy), 32'd0);
        chk("rst done",     32'(done), 32'd0);
        chk("rst error",    32'(error), 32'd0);
        chk("rst cpu_halt", 32'(cpu_halt), 32'd0);
        chk("rst we",       32'(write_enable), 32'd0);
        chk("rst addr",     32'(write_addr), 32'd0);
        chk("rst data",     32'(write_data), 32'd0);
        rst = 1'b0;
        tick();

        txq = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        run_load("two_word", 1'b0, 1'b0, 1'b1);

        txq = '{8'h00, 8'h00};
        run_load("zero_len", 1'b0, 1'b0, 1'b1);

        txq = '{8'h01, 8'h04};
        run_load("oversize", 1'b0, 1'b0, 1'b0);
        bw       = wq_addr.size();
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) tick();
        chk("err hold in_ready", 32'(in_ready), 32'd0);
        chk("err hold error",    32'(error), 32'd1);
        chk("err hold writes",   32'(wq_addr.size() - bw), 32'd0);
        in_valid = 1'b0;
        txq = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        run_load("recover", 1'b0, 1'b0, 1'b0);

        txq = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        run_load("two_word_gaps", 1'b1, 1'b0, 1'b0);

        // Reset right after the first of three words has been written.
        txq = '{8'h03, 8'h00};
        repeat (3*NB) txq.push_back(8'($urandom));
        bw = wq_addr.size();
        do_start(sc);
        send_bytes(1'b0, 1'b0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort writes",   32'(wq_addr.size() - bw), 32'd1);
        chk("abort in_ready", 32'(in_ready), 32'd0);
        chk("abort busy",     32'(busy), 32'd0);
        chk("abort done",     32'(done), 32'd0);
        chk("abort error",    32'(error), 32'd0);
        chk("abort cpu_halt", 32'(cpu_halt), 32'd0);
        chk("abort we",       32'(write_enable), 32'd0);
        chk("abort addr",     32'(write_addr), 32'd0);
        chk("abort data",     32'(write_data), 32'd0);
        txq = '{8'h01, 8'h00};
        repeat (NB) txq.push_back(8'($urandom));
        run_load("after_reset", 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 8);
            g = 1'($urandom_range(0, 1));
            txq = '{8'(n), 8'h00};
            repeat (n*NB) txq.push_back(8'($urandom));
            run_load($sformatf("rand%0d", k), g, 1'b1, !g);
        end

        txq = '{8'h00, 8'h04};
        repeat (SZ*NB) txq.push_back(8'($urandom));
        run_load("full_fill", 1'b0, 1'b1, 1'b1);

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
